// File: rtl/assert_ctrl_sequencer.sv
// Run-time controller for a bank of concurrent checkers: accepts on/off/
// freeze/thaw/clear commands, optionally time-limits off/freeze windows and
// restores them automatically, and keeps qualified-failure bookkeeping.
module assert_ctrl_sequencer #(
  parameter int N_CHK = 8,
  parameter int CNT_W = 16,
  localparam int IDX_W = (N_CHK > 1) ? $clog2(N_CHK) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [N_CHK-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [N_CHK-1:0] chk_fail,
  output logic [N_CHK-1:0] chk_en,
  output logic [N_CHK-1:0] chk_frozen,
  output logic [N_CHK-1:0] chk_kill,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail_vld,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [2:0] OP_ON     = 3'd1;
  localparam logic [2:0] OP_OFF    = 3'd2;
  localparam logic [2:0] OP_FREEZE = 3'd3;
  localparam logic [2:0] OP_THAW   = 3'd4;
  localparam logic [2:0] OP_CLR    = 3'd5;

  state_t             state_reg, state_next;
  logic [N_CHK-1:0]   en_reg, en_next;
  logic [N_CHK-1:0]   frozen_reg, frozen_next;
  logic [N_CHK-1:0]   kill_reg, kill_next;
  logic [CNT_W-1:0]   fail_cnt_reg, fail_cnt_next;
  logic               ff_vld_reg, ff_vld_next;
  logic [IDX_W-1:0]   ff_idx_reg, ff_idx_next;
  logic [CNT_W-1:0]   win_cnt_reg, win_cnt_next;
  logic               win_freeze_reg, win_freeze_next;
  logic [N_CHK-1:0]   win_mask_reg, win_mask_next;

  logic [N_CHK-1:0]   qual;
  logic [IDX_W-1:0]   low_idx;
  logic               do_clr;

  // A failure only counts when the checker is enabled and not frozen,
  // judged on the flags as they stood before this edge.
  for (genvar gi = 0; gi < N_CHK; gi++) begin : g_qual
    assign qual[gi] = chk_fail[gi] & en_reg[gi] & ~frozen_reg[gi];
  end

  // Lowest-index qualified checker (descending scan so the lowest wins).
  always_comb begin
    low_idx = '0;
    for (int i = N_CHK - 1; i >= 0; i--) begin
      if (qual[i]) low_idx = IDX_W'(i);
    end
  end

  // Next-state: command decode in IDLE, window countdown/restore in HOLD,
  // then failure bookkeeping (CLR takes priority over a same-edge failure).
  always_comb begin
    state_next      = state_reg;
    en_next         = en_reg;
    frozen_next     = frozen_reg;
    kill_next       = '0;
    fail_cnt_next   = fail_cnt_reg;
    ff_vld_next     = ff_vld_reg;
    ff_idx_next     = ff_idx_reg;
    win_cnt_next    = win_cnt_reg;
    win_freeze_next = win_freeze_reg;
    win_mask_next   = win_mask_reg;
    do_clr          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_ON:     en_next = en_reg | cmd_mask;
            OP_OFF: begin
              en_next   = en_reg & ~cmd_mask;
              kill_next = cmd_mask;
              if (cmd_len != '0) begin
                state_next      = HOLD;
                win_cnt_next    = cmd_len;
                win_freeze_next = 1'b0;
                win_mask_next   = cmd_mask;
              end
            end
            OP_FREEZE: begin
              frozen_next = frozen_reg | cmd_mask;
              if (cmd_len != '0) begin
                state_next      = HOLD;
                win_cnt_next    = cmd_len;
                win_freeze_next = 1'b1;
                win_mask_next   = cmd_mask;
              end
            end
            OP_THAW:   frozen_next = frozen_reg & ~cmd_mask;
            OP_CLR:    do_clr = 1'b1;
            default:   ;
          endcase
        end
      end
      HOLD: begin
        win_cnt_next = win_cnt_reg - CNT_W'(1);
        if (win_cnt_reg == CNT_W'(1)) begin
          state_next = IDLE;
          if (win_freeze_reg) frozen_next = frozen_reg & ~win_mask_reg;
          else                en_next     = en_reg | win_mask_reg;
        end
      end
      default: state_next = IDLE;
    endcase

    if (do_clr) begin
      fail_cnt_next = '0;
      ff_vld_next   = 1'b0;
      ff_idx_next   = '0;
    end else if (qual != '0) begin
      if (fail_cnt_reg != {CNT_W{1'b1}}) fail_cnt_next = fail_cnt_reg + CNT_W'(1);
      if (!ff_vld_reg) begin
        ff_vld_next = 1'b1;
        ff_idx_next = low_idx;
      end
    end
  end

  // State and output registers; reset abandons any open window without restore.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      en_reg         <= '1;
      frozen_reg     <= '0;
      kill_reg       <= '0;
      fail_cnt_reg   <= '0;
      ff_vld_reg     <= 1'b0;
      ff_idx_reg     <= '0;
      win_cnt_reg    <= '0;
      win_freeze_reg <= 1'b0;
      win_mask_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      en_reg         <= en_next;
      frozen_reg     <= frozen_next;
      kill_reg       <= kill_next;
      fail_cnt_reg   <= fail_cnt_next;
      ff_vld_reg     <= ff_vld_next;
      ff_idx_reg     <= ff_idx_next;
      win_cnt_reg    <= win_cnt_next;
      win_freeze_reg <= win_freeze_next;
      win_mask_reg   <= win_mask_next;
    end
  end

  assign cmd_ready      = (state_reg == IDLE);
  assign busy           = (state_reg == HOLD);
  assign chk_en         = en_reg;
  assign chk_frozen     = frozen_reg;
  assign chk_kill       = kill_reg;
  assign fail_cnt       = fail_cnt_reg;
  assign first_fail_vld = ff_vld_reg;
  assign first_fail_idx = ff_idx_reg;

endmodule

// File: tb/tb_assert_ctrl_sequencer.sv
// Bench for assert_ctrl_sequencer: a cycle-level reference model plus
// directed scenarios with literal expectations. A second instance with a
// 4-bit counter shares the stimulus to exercise saturation.
module tb_assert_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [7:0]  cmd_mask = 8'h00;
  logic [15:0] cmd_len = 16'h0;
  logic [7:0]  chk_fail = 8'h00;

  logic        cmd_ready, first_fail_vld, busy;
  logic [7:0]  chk_en, chk_frozen, chk_kill;
  logic [15:0] fail_cnt;
  logic [2:0]  first_fail_idx;

  logic        cmd_ready4, first_fail_vld4, busy4;
  logic [7:0]  chk_en4, chk_frozen4, chk_kill4;
  logic [3:0]  fail_cnt4;
  logic [2:0]  first_fail_idx4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  assert_ctrl_sequencer #(.N_CHK(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_len(cmd_len), .chk_fail(chk_fail),
    .chk_en(chk_en), .chk_frozen(chk_frozen), .chk_kill(chk_kill),
    .fail_cnt(fail_cnt), .first_fail_vld(first_fail_vld),
    .first_fail_idx(first_fail_idx), .busy(busy)
  );

  assert_ctrl_sequencer #(.N_CHK(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_len(cmd_len[3:0]), .chk_fail(chk_fail),
    .chk_en(chk_en4), .chk_frozen(chk_frozen4), .chk_kill(chk_kill4),
    .fail_cnt(fail_cnt4), .first_fail_vld(first_fail_vld4),
    .first_fail_idx(first_fail_idx4), .busy(busy4)
  );

  always #5 clk = ~clk;
  always @(negedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the checker flags directly and the open window as "cycles left".
  logic [7:0] m_en = 8'hFF, m_frz = 8'h00, m_kill = 8'h00, m_q, m_wmask = 8'h00;
  int m_cnt16 = 0, m_cnt4 = 0, m_idx = 0, m_left = 0;
  bit m_vld = 0, m_wfrz = 0, m_clr, m_found;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en = 8'hFF; m_frz = 8'h00; m_kill = 8'h00;
      m_cnt16 = 0; m_cnt4 = 0; m_vld = 0; m_idx = 0; m_left = 0;
    end else begin
      m_q = chk_fail & m_en & ~m_frz;
      m_kill = 8'h00;
      m_clr = 0;
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_wfrz) m_frz = m_frz & ~m_wmask;
          else        m_en  = m_en | m_wmask;
        end
      end else if (cmd_valid) begin
        case (cmd_op)
          3'd1: m_en = m_en | cmd_mask;
          3'd2: begin
            m_en = m_en & ~cmd_mask; m_kill = cmd_mask;
            m_left = int'(cmd_len); m_wfrz = 0; m_wmask = cmd_mask;
          end
          3'd3: begin
            m_frz = m_frz | cmd_mask;
            m_left = int'(cmd_len); m_wfrz = 1; m_wmask = cmd_mask;
          end
          3'd4: m_frz = m_frz & ~cmd_mask;
          3'd5: m_clr = 1;
          default: ;
        endcase
      end
      if (m_clr) begin
        m_cnt16 = 0; m_cnt4 = 0; m_vld = 0; m_idx = 0;
      end else if (m_q != 8'h00) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
        if (!m_vld) begin
          m_vld = 1;
          m_found = 0;
          for (int i = 0; i < 8; i++) begin
            if (m_q[i] && !m_found) begin m_idx = i; m_found = 1; end
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_chk_en",     chk_en,         m_en);
    check("cmp_chk_frozen", chk_frozen,     m_frz);
    check("cmp_chk_kill",   chk_kill,       m_kill);
    check("cmp_fail_cnt",   fail_cnt,       m_cnt16);
    check("cmp_ff_vld",     first_fail_vld, m_vld);
    check("cmp_ff_idx",     first_fail_idx, m_idx);
    check("cmp_busy",       busy,           (m_left != 0));
    check("cmp_cmd_ready",  cmd_ready,      (m_left == 0));
    check("cmp_fail_cnt4",  fail_cnt4,      m_cnt4);
    check("cmp_chk_en4",    chk_en4,        m_en);
  end

  // ---------------- stimulus helpers ----------------
  // Call #1 after a rising edge; returns #1 after the accept edge.
  task automatic send(input logic [2:0] op, input logic [7:0] mask,
                      input logic [15:0] len, output int acc_cyc);
    bit ok = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask; cmd_len = len;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
    end
    check("send_accept", ok, 1);
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_mask = 8'h00; cmd_len = 16'h0;
  endtask

  task automatic check_reset_vals();
    check("rst_chk_en", chk_en, 8'hFF);
    check("rst_chk_frozen", chk_frozen, 8'h00);
    check("rst_chk_kill", chk_kill, 8'h00);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_ff_vld", first_fail_vld, 0);
    check("rst_ff_idx", first_fail_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 1);
  endtask

  // Asserts reset #1 after an edge, checks it, releases #1 after a later edge.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int a0, a1, busy_n, frz_n;

  initial begin
    // Reset and first-failure basics.
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rst_n = 1'b1;
    chk_fail = 8'h01;
    repeat (3) @(posedge clk);
    #1 chk_fail = 8'h00;
    check("t1_fail_cnt", fail_cnt, 3);
    check("t1_ff_vld", first_fail_vld, 1);
    check("t1_ff_idx", first_fail_idx, 0);

    // Untimed OFF with kill pulse; disabled checkers do not count.
    send(3'd2, 8'h0F, 16'd0, a0);
    check("t2_en_off", chk_en, 8'hF0);
    check("t2_kill", chk_kill, 8'h0F);
    chk_fail = 8'h0F;
    @(posedge clk); #1;
    check("t2_kill_gone", chk_kill, 8'h00);
    @(posedge clk); #1;
    chk_fail = 8'h00;
    check("t2_cnt_same", fail_cnt, 3);
    send(3'd1, 8'h0F, 16'd0, a0);
    check("t2_en_on", chk_en, 8'hFF);

    // Timed FREEZE of 4 cycles with a command queued behind it.
    send(3'd3, 8'hFF, 16'd4, a0);
    check("t3_frozen", chk_frozen, 8'hFF);
    check("t3_busy", busy, 1);
    check("t3_ready", cmd_ready, 0);
    busy_n = 0; frz_n = 0;
    fork
      send(3'd2, 8'h80, 16'd0, a1);
      begin
        chk_fail = 8'hFF;
        repeat (4) @(posedge clk);
        #1 chk_fail = 8'h00;
      end
      begin
        repeat (6) begin
          @(negedge clk);
          if (busy) busy_n++;
          if (chk_frozen == 8'hFF) frz_n++;
        end
      end
    join
    check("t3_busy_cycles", busy_n, 4);
    check("t3_frozen_cycles", frz_n, 4);
    check("t3_accept_delay", a1 - a0, 5);
    check("t3_cnt_same", fail_cnt, 3);
    check("t3_en_after", chk_en, 8'h7F);
    @(posedge clk); #1;
    send(3'd1, 8'h80, 16'd0, a0);

    // First-failure index from reset, then after CLR.
    chk_fail = 8'h24;
    do_reset();
    repeat (2) @(posedge clk);
    #1 chk_fail = 8'h00;
    check("t4_idx2", first_fail_idx, 2);
    check("t4_cnt2", fail_cnt, 2);
    send(3'd5, 8'h00, 16'd0, a0);
    check("t4_clr_cnt", fail_cnt, 0);
    check("t4_clr_vld", first_fail_vld, 0);
    chk_fail = 8'h80;
    @(posedge clk); #1 chk_fail = 8'h00;
    check("t4_idx7", first_fail_idx, 7);
    check("t4_cnt1", fail_cnt, 1);

    // Saturation of the narrow counter; CLR beats a same-edge failure.
    chk_fail = 8'h01;
    repeat (20) @(posedge clk);
    #1;
    check("t5_cnt16", fail_cnt, 21);
    check("t5_cnt4_sat", fail_cnt4, 15);
    send(3'd5, 8'h00, 16'd0, a0);
    chk_fail = 8'h00;
    check("t5_clr_cnt", fail_cnt, 0);
    check("t5_clr_cnt4", fail_cnt4, 0);
    check("t5_clr_vld", first_fail_vld, 0);

    // Reset in the middle of a timed OFF window.
    send(3'd2, 8'h03, 16'd10, a0);
    check("t6_en", chk_en, 8'hFC);
    check("t6_kill", chk_kill, 8'h03);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("t6_idle_ready", cmd_ready, 1);
    check("t6_idle_busy", busy, 0);
    check("t6_en_after", chk_en, 8'hFF);

    // Back-to-back untimed commands; frozen checkers do not qualify.
    send(3'd3, 8'h03, 16'd0, a0);
    send(3'd4, 8'h01, 16'd0, a1);
    check("t7_b2b", a1 - a0, 1);
    check("t7_frozen", chk_frozen, 8'h02);
    chk_fail = 8'h03;
    @(posedge clk); #1 chk_fail = 8'h00;
    check("t7_cnt", fail_cnt, 1);
    check("t7_idx", first_fail_idx, 0);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
